// File: rtl/rf_sched_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Used by regfile_wb_scheduler and rf_scoreboard.
package rf_sched_pkg;

  localparam int REG_COUNT = 32;
  localparam int X0_ADDR   = 0;
  localparam int WB_ADDR_W = $clog2(REG_COUNT);
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue
// allocation, cleared on write-back; x0 never reports busy.
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rd_busy,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int REGS = 2 ** ADDR_WIDTH;

  logic [REGS-1:0] busy;

  // Set is applied after clear so an allocation in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_busy  = busy[rd_addr];
    rs1_busy = busy[rs1_addr] && (rs1_addr != ADDR_WIDTH'(X0_ADDR));
    rs2_busy = busy[rs2_addr] && (rs2_addr != ADDR_WIDTH'(X0_ADDR));
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter and hazard scoreboard in front of the regfile write port.
// Define RF_WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the load unit (req 1) wins.
// Handshake: a requester transfers when valid && ready in the same cycle; a
// requester that is not ready must hold valid/addr/data until it is.
module regfile_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb0_valid,
  input  logic [ADDR_WIDTH-1:0] wb0_addr,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [ADDR_WIDTH-1:0] wb1_addr,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic                  wb1_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  logic                  grant0;
  logic                  grant1;
  logic                  wb_fire;
  logic                  wb_nonzero;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  rd_busy;
  logic                  issue_fire;

`ifdef RF_WB_ROUND_ROBIN_EN
  logic rr_ptr;  // 0: requester 0 preferred on conflict

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (wb0_valid && wb1_valid) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (wb0_valid && wb1_valid) begin
`ifdef RF_WB_ROUND_ROBIN_EN
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
`else
        grant1 = 1'b1;
`endif
      end else begin
        grant0 = wb0_valid;
        grant1 = wb1_valid;
      end
    end
  end

  always_comb begin
    wb0_ready  = grant0;
    wb1_ready  = grant1;
    wb_fire    = grant0 || grant1;
    wb_addr    = grant1 ? wb1_addr : wb0_addr;
    wb_data    = grant1 ? wb1_data : wb0_data;
    wb_nonzero = (wb_addr != ADDR_WIDTH'(X0_ADDR));
  end

  // A WAW stall keeps at most one outstanding write per register.
  always_comb begin
    issue_ready = !rd_busy || (issue_rd == ADDR_WIDTH'(X0_ADDR));
    issue_fire  = issue_valid && issue_ready && (issue_rd != ADDR_WIDTH'(X0_ADDR));
  end

  // x0 writes complete the handshake but never pulse the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_fire && wb_nonzero;
      if (wb_fire) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_fire),
    .set_addr (issue_rd),
    .clr_en   (wb_fire && wb_nonzero),
    .clr_addr (wb_addr),
    .rd_addr  (issue_rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_busy  (rd_busy),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Write-back scheduler and hazard scoreboard for the 32-entry RISC-V register file (x0 hardwired zero, one write port, two read ports).
- Arbitrates two write-back requesters (req 0 = ALU, req 1 = load unit) onto the single regfile write port.
- Tracks registers with outstanding writes so the issue stage can stall on RAW/WAW hazards.
- Sits between execute/memory units and the regfile write port; its outputs drive the regfile's reg_write/write_addr/write_data directly.

Parameters:
- DATA_WIDTH, 32, write-data width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wb0_valid  in  1  requester 0 write-back request
- wb0_addr  in  ADDR_WIDTH  requester 0 destination register
- wb0_data  in  DATA_WIDTH  requester 0 data
- wb0_ready  out  1  requester 0 granted this cycle
- wb1_valid / wb1_addr / wb1_data / wb1_ready  same as above, for requester 1
- issue_valid  in  1  issue stage allocating a destination
- issue_rd  in  ADDR_WIDTH  destination being allocated
- issue_ready  out  1  allocation accepted
- rs1_addr, rs2_addr  in  ADDR_WIDTH  source registers of the instruction in issue
- rs1_busy, rs2_busy  out  1  source has an outstanding write
- rf_we  out  1  regfile reg_write
- rf_waddr  out  ADDR_WIDTH  regfile write_addr
- rf_wdata  out  DATA_WIDTH  regfile write_data

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, busy[*]=0, round-robin pointer=0 (requester 0 has priority first).
- Grant is combinational in the current cycle:
  - Exactly one of wbN_ready is high when any wbN_valid is high.
  - Handshake completes when valid && ready.
  - The loser keeps valid, addr and data stable until granted.
- Output stage is registered; latency is one cycle from handshake to rf_we pulse.
  - The output stage always drains (the regfile accepts every cycle), so there is no output backpressure.
- Arbitration:
  - Both valid: the requester indicated by the pointer wins.
  - Pointer flips to the other requester after any grant made while both were valid.
  - Single valid: that requester wins and the pointer is unchanged.
- x0 write:
  - The handshake completes normally.
  - rf_we stays 0 the next cycle and no busy bit changes.
- Scoreboard:
  - busy[r] is set on an issue handshake with r != 0.
  - busy[r] is cleared on a write-back handshake to r.
  - Set and clear on the same register in the same cycle: set wins, busy stays 1.
  - issue_ready = !busy[issue_rd] || issue_rd == 0. This is a WAW stall, so at most one write per register is ever outstanding.
- rsN_busy = busy[rsN_addr] && rsN_addr != 0, read combinationally from registered state. No same-cycle bypass.
- A write-back to a register that is not busy is legal: it is written and busy stays 0.
- Reset asserted mid-operation:
  - Pending grants are dropped and all busy bits clear immediately.
  - rf_we deasserts asynchronously.

Optional Feature:
- Macro RF_WB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as specified above.
- Undefined: fixed priority, requester 1 (load unit) always wins on conflict. The pointer register is not built.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package rf_sched_pkg holds:
  - REG_COUNT=32
  - X0_ADDR=0
  - typedef wb_req_t {valid, addr, data}
- One natural sub-module, rf_scoreboard: busy vector, set/clear logic and the two read lookups.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset with wb0_valid=1 asserted -> rf_we=0, wb0_ready and wb1_ready low while rst=1, busy all 0. After release, wb0 (addr 5, data 0xA5A5A5A5) is granted and rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5 one cycle later.
- Both requesters valid for 4 cycles (wb0 addr 1, wb1 addr 2):
  - With RF_WB_ROUND_ROBIN_EN: grants 0,1,0,1.
  - Without: grants 1,1,1,1 while wb0 holds stable.
- Issue rd=7 -> rs1_addr=7 gives rs1_busy=1; a second issue rd=7 gives issue_ready=0. Write-back to 7 completes -> next cycle busy clear and issue_ready=1.
- Same cycle: write-back handshake to x9 and issue of x9 -> busy[9]=1 afterwards, rf_we=1 with rf_waddr=9.
- wb1 write to x0 with data 0xFFFFFFFF -> wb1_ready=1, rf_we=0 next cycle. issue_rd=0 -> issue_ready=1 and busy unchanged; rs2_addr=0 -> rs2_busy=0.
- Asynchronous rst pulse mid-cycle with busy[3]=1 and rf_we=1 -> rf_we and busy[3] drop before the next clock edge.
